// File: rtl/wb_sched_if.sv
// wb_sched_if: core, load-response and register-file write signals of the writeback scheduler
interface wb_sched_if;
   logic        core_valid;
   logic [1:0]  core_sel;
   logic [4:0]  core_rd;
   logic [31:0] core_alu;
   logic [31:0] core_jaddr;
   logic        core_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [1:0]  WBsel;
   modport master (
      output core_valid, core_sel, core_rd, core_alu, core_jaddr, ld_valid, ld_rd, ld_data,
      input  core_ready, ld_ready, rf_we, rf_rd, rf_wdata, WBsel
   );
   modport slave (
      input  core_valid, core_sel, core_rd, core_alu, core_jaddr, ld_valid, ld_rd, ld_data,
      output core_ready, ld_ready, rf_we, rf_rd, rf_wdata, WBsel
   );
endinterface

// File: rtl/wb_sched.sv
// wb_sched: arbitrates core results and buffered load responses onto a single register-file write port
module wb_sched #(
   parameter int LD_DEPTH = 2
) (
   input logic       clk,
   input logic       rst,
   wb_sched_if.slave bus
);
   localparam int PW = $clog2(LD_DEPTH);
   logic [4:0]  q_rd   [LD_DEPTH];
   logic [31:0] q_data [LD_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0]   count;
   logic last_fifo, waw, full, pop, push;
   assign full = count == (PW+1)'(LD_DEPTH);
   assign bus.ld_ready = !full;
   assign push = bus.ld_valid && bus.ld_ready;
   // the head goes first when full, on a WAW hit, when the core is idle, or when it is the head's turn
   assign pop = count != '0 && (full || waw || !bus.core_valid || !last_fifo);
   assign bus.core_ready = bus.core_valid && !pop && !rst;
   // WAW hazard: core destination matches any load still waiting in the buffer
   always_comb begin
      waw = 1'b0;
      for (int k = 0; k < LD_DEPTH; k++)
         waw = waw | (k < int'(count) && q_rd[rp + PW'(k)] == bus.core_rd);
      waw = waw && bus.core_valid && bus.core_rd != 5'd0;
   end
   // load buffer storage, pointers, occupancy and round-robin turn
   always_ff @(posedge clk) begin
      if (rst) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         last_fifo <= 1'b1;
      end else begin
         if (push) begin
            q_rd[wp]   <= bus.ld_rd;
            q_data[wp] <= bus.ld_data;
            wp         <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         count     <= count + (PW+1)'(push) - (PW+1)'(pop);
         last_fifo <= pop ? 1'b1 : bus.core_ready ? 1'b0 : last_fifo;
      end
   end
   // registered write port; writes to x0 are consumed without a write strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rf_we    <= 1'b0;
         bus.rf_rd    <= '0;
         bus.rf_wdata <= '0;
         bus.WBsel    <= 2'b01;
      end else if (pop) begin
         bus.rf_we    <= q_rd[rp] != 5'd0;
         bus.rf_rd    <= q_rd[rp];
         bus.rf_wdata <= q_data[rp];
         bus.WBsel    <= 2'b00;
      end else if (bus.core_ready) begin
         bus.rf_we    <= bus.core_rd != 5'd0;
         bus.rf_rd    <= bus.core_rd;
         bus.rf_wdata <= bus.core_sel == 2'b10 ? bus.core_jaddr : bus.core_alu;
         bus.WBsel    <= bus.core_sel == 2'b10 ? 2'b10 : 2'b01;
      end else begin
         bus.rf_we    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed vector table, alternation sequence and randomized run against a queue model
module tb_wb_sched;
   localparam int DEPTH = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   wb_sched_if bus ();
   wb_sched #(.LD_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        r, cv;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic [31:0] alu, jaddr;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic        cr, lr, we;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic [1:0]  ws;
   } vec_t;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ld_t;

   vec_t tv[$];
   ld_t  mq[$];
   bit   m_last_core;
   int   n_cmp = 0, n_bad = 0;
   logic a_cr, a_lr, a_we, e_cr, e_lr, e_we;
   logic [4:0]  a_rd, e_rd;
   logic [31:0] a_wd, e_wd;
   logic [1:0]  a_ws, e_ws;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t t(input logic r, cv, input logic [1:0] sel, input logic [4:0] rd,
                              input logic [31:0] alu, jaddr, input logic lv, input logic [4:0] lrd,
                              input logic [31:0] ldata, input logic cr, lr, we,
                              input logic [4:0] wrd, input logic [31:0] wd, input logic [1:0] ws);
      vec_t v;
      v.r = r; v.cv = cv; v.sel = sel; v.rd = rd; v.alu = alu; v.jaddr = jaddr;
      v.lv = lv; v.lrd = lrd; v.ldata = ldata;
      v.cr = cr; v.lr = lr; v.we = we; v.wrd = wrd; v.wd = wd; v.ws = ws;
      return v;
   endfunction

   // one clock: drive, sample handshakes mid-cycle, sample write port after the edge, advance the model
   task automatic step(input logic r, cv, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [31:0] alu, jaddr, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldata);
      bit hit, gf, gc;
      ld_t h;
      @(negedge clk);
      rst = r; bus.core_valid = cv; bus.core_sel = sel; bus.core_rd = rd;
      bus.core_alu = alu; bus.core_jaddr = jaddr;
      bus.ld_valid = lv; bus.ld_rd = lrd; bus.ld_data = ldata;
      #1;
      a_cr = bus.core_ready;
      a_lr = bus.ld_ready;
      hit = 0;
      foreach (mq[i]) if (mq[i].rd == rd) hit = 1;
      gf = mq.size() > 0 && (mq.size() == DEPTH || (cv && rd != 0 && hit) || !cv || m_last_core);
      gc = cv && !gf && !r;
      e_cr = gc;
      e_lr = mq.size() < DEPTH;
      @(posedge clk);
      #1;
      a_we = bus.rf_we; a_rd = bus.rf_rd; a_wd = bus.rf_wdata; a_ws = bus.WBsel;
      if (r) begin
         mq.delete();
         m_last_core = 0;
         e_we = 0; e_rd = 0; e_wd = 0; e_ws = 2'b01;
      end else begin
         if (gf) begin
            h = mq.pop_front();
            e_we = h.rd != 0; e_rd = h.rd; e_wd = h.d; e_ws = 2'b00;
            m_last_core = 0;
         end else if (gc) begin
            e_we = rd != 0; e_rd = rd; e_wd = sel == 2'b10 ? jaddr : alu;
            e_ws = sel == 2'b10 ? 2'b10 : 2'b01;
            m_last_core = 1;
         end else e_we = 0;
         if (lv && e_lr) begin
            h.rd = lrd; h.d = ldata;
            mq.push_back(h);
         end
      end
   endtask

   initial begin
      bus.core_valid = 0; bus.core_sel = 0; bus.core_rd = 0; bus.core_alu = 0; bus.core_jaddr = 0;
      bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
      tv.push_back(t(1,0,1, 0,32'h0,   32'h0,  0, 0,32'h0,    0,1,0, 0,32'h0,    2'b01));
      tv.push_back(t(0,1,1, 5,32'h1234,32'h0,  0, 0,32'h0,    1,1,1, 5,32'h1234, 2'b01));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  1, 3,32'hAAAA, 0,1,0, 5,32'h1234, 2'b01));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  1, 4,32'hBBBB, 0,1,1, 3,32'hAAAA, 2'b00));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  0, 0,32'h0,    0,1,1, 4,32'hBBBB, 2'b00));
      tv.push_back(t(0,1,1,10,32'h55,  32'h0,  1,11,32'hC1,   1,1,1,10,32'h55,   2'b01));
      tv.push_back(t(0,1,1,12,32'h66,  32'h0,  1,13,32'hC2,   0,1,1,11,32'hC1,   2'b00));
      tv.push_back(t(0,1,1,14,32'h77,  32'h0,  1,15,32'hC3,   1,1,1,14,32'h77,   2'b01));
      tv.push_back(t(0,1,1,16,32'h88,  32'h0,  1,17,32'hC4,   0,0,1,13,32'hC2,   2'b00));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  0, 0,32'h0,    0,1,1,15,32'hC3,   2'b00));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  1, 7,32'h77,   0,1,0,15,32'hC3,   2'b00));
      tv.push_back(t(0,1,2, 7,32'hDEAD,32'h40, 0, 0,32'h0,    0,1,1, 7,32'h77,   2'b00));
      tv.push_back(t(0,1,2, 7,32'hDEAD,32'h40, 0, 0,32'h0,    1,1,1, 7,32'h40,   2'b10));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  1, 0,32'h99,   0,1,0, 7,32'h40,   2'b10));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  0, 0,32'h0,    0,1,0, 0,32'h99,   2'b00));
      tv.push_back(t(0,1,3, 6,32'h66,  32'h1,  0, 0,32'h0,    1,1,1, 6,32'h66,   2'b01));
      tv.push_back(t(0,1,2, 0,32'h0,   32'h123,0, 0,32'h0,    1,1,0, 0,32'h123,  2'b10));
      tv.push_back(t(0,1,1, 8,32'h81,  32'h0,  1,20,32'hD0,   1,1,1, 8,32'h81,   2'b01));
      tv.push_back(t(0,1,1, 9,32'h91,  32'h0,  1,21,32'hD1,   0,1,1,20,32'hD0,   2'b00));
      tv.push_back(t(0,1,1, 9,32'h91,  32'h0,  1,22,32'hD2,   1,1,1, 9,32'h91,   2'b01));
      tv.push_back(t(1,1,1, 9,32'h91,  32'h0,  1,23,32'hD3,   0,0,0, 0,32'h0,    2'b01));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  0, 0,32'h0,    0,1,0, 0,32'h0,    2'b01));
      tv.push_back(t(0,0,1, 0,32'h0,   32'h0,  0, 0,32'h0,    0,1,0, 0,32'h0,    2'b01));
      step(1,0,1,0,0,0,0,0,0);
      step(1,0,1,0,0,0,0,0,0);
      foreach (tv[i]) begin
         step(tv[i].r, tv[i].cv, tv[i].sel, tv[i].rd, tv[i].alu, tv[i].jaddr, tv[i].lv, tv[i].lrd, tv[i].ldata);
         chk($sformatf("vec%0d core_ready", i), a_cr, tv[i].cr);
         chk($sformatf("vec%0d ld_ready", i), a_lr, tv[i].lr);
         chk($sformatf("vec%0d rf_we", i), a_we, tv[i].we);
         chk($sformatf("vec%0d rf_rd", i), a_rd, tv[i].wrd);
         chk($sformatf("vec%0d rf_wdata", i), a_wd, tv[i].wd);
         chk($sformatf("vec%0d WBsel", i), a_ws, tv[i].ws);
      end
      // core and a single load kept pending: grants must alternate core, load, core...
      step(1,0,1,0,0,0,0,0,0);
      step(0,0,1,0,0,0,1,2,32'hFF);
      for (int k = 0; k < 10; k++) begin
         step(0,1,1,1,32'(k),0,k[0],2,32'h100 + 32'(k));
         chk($sformatf("alt%0d core_ready", k), a_cr, !k[0]);
         chk($sformatf("alt%0d ld_ready", k), a_lr, 1);
         chk($sformatf("alt%0d rf_rd", k), a_rd, k[0] ? 2 : 1);
         chk($sformatf("alt%0d rf_wdata", k), a_wd, k[0] ? 32'h100 + 32'(k) - 2 : 32'(k));
         chk($sformatf("alt%0d WBsel", k), a_ws, k[0] ? 2'b00 : 2'b01);
      end
      // randomized traffic against the queue model
      step(1,0,1,0,0,0,0,0,0);
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0,63) == 0, $urandom_range(0,2) != 0, 2'($urandom_range(0,3)),
              5'($urandom_range(0,7)), $urandom, $urandom, $urandom_range(0,1) == 1,
              5'($urandom_range(0,7)), $urandom);
         chk("rnd core_ready", a_cr, e_cr);
         chk("rnd ld_ready", a_lr, e_lr);
         chk("rnd rf_we", a_we, e_we);
         chk("rnd rf_rd", a_rd, e_rd);
         chk("rnd rf_wdata", a_wd, e_wd);
         chk("rnd WBsel", a_ws, e_ws);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
